weight_loader: RTL and testbench



---
 rtl/wl_pkg.sv | 23 ++
 rtl/wl_kernel_shift.sv | 37 +++
 rtl/weight_loader.sv | 138 +++++++++++++
 tb/tb_weight_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wl_pkg.sv
// Shared definitions for the kernel-weight loader.
//   wl_state_e    : loader FSM encoding (IDLE, FETCH, DRAIN, DONE)
//   ROM_LAT_MAX   : largest supported ROM read latency
//   kernel_offset : bit offset of kernel k of MAC m in the packed kernel bus
package wl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wl_state_e;

  localparam int unsigned ROM_LAT_MAX = 4;

  function automatic int unsigned kernel_offset(input int unsigned m,
                                                input int unsigned k,
                                                input int unsigned taps,
                                                input int unsigned kw);
    return (m * taps + k) * kw;
  endfunction

endpackage

// File: rtl/wl_kernel_shift.sv
// Per-MAC kernel shift register, TAPS deep and KERNEL_WIDTH wide.
// Each capture beat shifts toward slot 0 and loads i_data into slot TAPS-1,
// so after TAPS beats slot 0 holds the first word captured.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   i_capture  : shift enable
//   i_data     : word entering slot TAPS-1
//   o_slots    : all slots, slot k at [k*KERNEL_WIDTH +: KERNEL_WIDTH]
module wl_kernel_shift
  import wl_pkg::*;
#(
  parameter int unsigned TAPS         = 3,
  parameter int unsigned KERNEL_WIDTH = 72
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_capture,
  input  logic [KERNEL_WIDTH-1:0]      i_data,
  output logic [TAPS*KERNEL_WIDTH-1:0] o_slots
);

  logic [KERNEL_WIDTH-1:0] r_slot [TAPS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < TAPS; k++) r_slot[k] <= '0;
    end else if (i_capture) begin
      for (int unsigned k = 0; k + 1 < TAPS; k++) r_slot[k] <= r_slot[k+1];
      r_slot[TAPS-1] <= i_data;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_out
    assign o_slots[kernel_offset(0, k, TAPS, KERNEL_WIDTH) +: KERNEL_WIDTH] = r_slot[k];
  end

endmodule

// File: rtl/weight_loader.sv
// Kernel-weight loader for the conv MAC array.
// On i_start (accepted in IDLE/DONE) fetches TAPS consecutive ROM words from
// i_base_addr (address wraps modulo 2^ADDR_WIDTH) and shifts them into the
// per-MAC kernel registers; o_ready flags a complete kernel set.
// Optional build macro WL_SHADOW_EN: captures go to a shadow bank that is
// copied to the visible bank on entering DONE; o_ready follows one cycle later.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   i_start       : one-cycle load request
//   i_base_addr   : first ROM word, sampled with an accepted i_start
//   o_busy        : load in progress (FETCH or DRAIN)
//   o_ready       : kernel set complete and stable
//   o_rom_en      : shared ROM enable
//   o_rom_addr    : shared ROM address
//   i_rom_data    : ROM outputs, MAC m at slice m
//   o_kernels     : kernel k of MAC m at slice (m*TAPS+k)
//   o_err         : sticky, i_start seen while busy
module weight_loader
  import wl_pkg::*;
#(
  parameter int unsigned NUM_MAC      = 4,
  parameter int unsigned TAPS         = 3,
  parameter int unsigned KERNEL_WIDTH = 72,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned ROM_LAT      = 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 i_start,
  input  logic [ADDR_WIDTH-1:0]                i_base_addr,
  output logic                                 o_busy,
  output logic                                 o_ready,
  output logic                                 o_rom_en,
  output logic [ADDR_WIDTH-1:0]                o_rom_addr,
  input  logic [NUM_MAC*KERNEL_WIDTH-1:0]      i_rom_data,
  output logic [NUM_MAC*TAPS*KERNEL_WIDTH-1:0] o_kernels,
  output logic                                 o_err
);

  localparam int unsigned LAT    = (ROM_LAT < 1) ? 1 :
                                   ((ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT);
  localparam int unsigned CW     = $clog2(TAPS + 1);
  localparam int unsigned SLOTS_W = TAPS * KERNEL_WIDTH;
  localparam int unsigned BANK_W  = NUM_MAC * SLOTS_W;

  wl_state_e             r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_capture_cnt;
  logic [LAT-1:0]        r_vld;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_fetch;
  logic                  w_capture;
  logic [BANK_W-1:0]     w_shift_bank;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE, DONE: if (i_start) begin
        w_accept     = 1'b1;
        w_state_next = FETCH;
      end
      FETCH: if (r_issue_cnt == CW'(TAPS - 1)) w_state_next = DRAIN;
      // Wait on the registered count so ready lands TAPS+ROM_LAT+1 edges after start.
      DRAIN: if (r_capture_cnt == CW'(TAPS)) w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_fetch    = (r_state == FETCH);
  assign o_rom_en   = w_fetch;
  assign o_rom_addr = w_fetch ? (r_base + ADDR_WIDTH'(r_issue_cnt)) : '0;
  assign o_busy     = (r_state == FETCH) || (r_state == DRAIN);
  assign o_err      = r_err;
  assign w_capture  = r_vld[LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_base        <= '0;
      r_issue_cnt   <= '0;
      r_capture_cnt <= '0;
      r_vld         <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Valid pipe mirrors the ROM latency; the cast drops the oldest stage.
      r_vld   <= LAT'({r_vld, w_fetch});
      if (w_accept) begin
        r_base        <= i_base_addr;
        r_issue_cnt   <= '0;
        r_capture_cnt <= '0;
      end else begin
        if (w_fetch)   r_issue_cnt   <= r_issue_cnt + 1'b1;
        if (w_capture) r_capture_cnt <= r_capture_cnt + 1'b1;
      end
      if (i_start && o_busy) r_err <= 1'b1;
    end
  end

  for (genvar m = 0; m < NUM_MAC; m++) begin : g_mac
    wl_kernel_shift #(
      .TAPS         (TAPS),
      .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_shift (
      .clk       (clk),
      .rstn      (rstn),
      .i_capture (w_capture),
      .i_data    (i_rom_data[m*KERNEL_WIDTH +: KERNEL_WIDTH]),
      .o_slots   (w_shift_bank[kernel_offset(m, 0, TAPS, KERNEL_WIDTH) +: SLOTS_W])
    );
  end

`ifdef WL_SHADOW_EN
  logic [BANK_W-1:0] r_active;
  logic              r_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= '0;
      r_ready  <= 1'b0;
    end else begin
      if ((r_state == DRAIN) && (w_state_next == DONE)) r_active <= w_shift_bank;
      // Ready trails the bank copy by one cycle and drops with an accepted start.
      r_ready <= (r_state == DONE) && (w_state_next == DONE);
    end
  end

  assign o_kernels = r_active;
  assign o_ready   = r_ready;
`else
  assign o_kernels = w_shift_bank;
  assign o_ready   = (r_state == DONE);
`endif

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;
  import wl_pkg::*;

  localparam int unsigned NM = 4;
  localparam int unsigned TP = 3;
  localparam int unsigned KW = 72;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = NM * TP * KW;
`ifdef WL_SHADOW_EN
  localparam int unsigned SH = 1;
`else
  localparam int unsigned SH = 0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic i_start;
  logic [AW-1:0] i_base_addr;

  logic busy_a, ready_a, en_a, err_a;
  logic [AW-1:0] addr_a;
  logic [NM*KW-1:0] data_a;
  logic [BW-1:0] kern_a;
  logic busy_b, ready_b, en_b, err_b;
  logic [AW-1:0] addr_b;
  logic [NM*KW-1:0] data_b;
  logic [BW-1:0] kern_b;

  logic [NM*KW-1:0] rom_b_p1, rom_b_p2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  weight_loader #(.NUM_MAC(NM), .TAPS(TP), .KERNEL_WIDTH(KW), .ADDR_WIDTH(AW), .ROM_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr),
    .o_busy(busy_a), .o_ready(ready_a), .o_rom_en(en_a), .o_rom_addr(addr_a),
    .i_rom_data(data_a), .o_kernels(kern_a), .o_err(err_a));

  weight_loader #(.NUM_MAC(NM), .TAPS(TP), .KERNEL_WIDTH(KW), .ADDR_WIDTH(AW), .ROM_LAT(3)) dut_b (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr),
    .o_busy(busy_b), .o_ready(ready_b), .o_rom_en(en_b), .o_rom_addr(addr_b),
    .i_rom_data(data_b), .o_kernels(kern_b), .o_err(err_b));

  // ROM word for MAC m at address a: {mac_id, addr} with the id repeated high.
  function automatic logic [KW-1:0] rom_word(input int unsigned m, input logic [AW-1:0] a);
    logic [7:0] id8;
    logic [5:0] id6;
    id8 = 8'(m);
    id6 = 6'(m);
    return {id8, 48'h0, id6, a};
  endfunction

  // Unenabled reads return all ones so a mistimed capture is visible.
  function automatic logic [NM*KW-1:0] rom_row(input logic en, input logic [AW-1:0] a);
    logic [NM*KW-1:0] row;
    for (int m = 0; m < NM; m++) row[m*KW +: KW] = en ? rom_word(m, a) : '1;
    return row;
  endfunction

  function automatic logic [BW-1:0] exp_bank(input logic [AW-1:0] base);
    logic [BW-1:0] v;
    logic [AW-1:0] a;
    v = '0;
    for (int m = 0; m < NM; m++)
      for (int k = 0; k < TP; k++) begin
        a = base + AW'(k);
        v[kernel_offset(m, k, TP, KW) +: KW] = rom_word(m, a);
      end
    return v;
  endfunction

  always @(posedge clk) data_a <= rom_row(en_a, addr_a);
  always @(posedge clk) begin
    rom_b_p1 <= rom_row(en_b, addr_b);
    rom_b_p2 <= rom_b_p1;
    data_b   <= rom_b_p2;
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW-1:0] base);
    i_start     = 1'b1;
    i_base_addr = base;
    tick();
    i_start     = 1'b0;
  endtask

  logic [BW-1:0] bank_a0, bank_w;
  logic [AW-1:0] ea;
  logic [AW-1:0] wrap_addr [TP];

  initial begin
    wrap_addr[0] = 10'h3FF;
    wrap_addr[1] = 10'h000;
    wrap_addr[2] = 10'h001;
    bank_a0 = exp_bank(10'h010);
    bank_w  = exp_bank(10'h3FF);

    rstn = 1'b0; i_start = 1'b0; i_base_addr = '0;
    repeat (2) tick();
    check("rst_busy", busy_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_en", en_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_err", err_a, 0);
    check("rst_kern", kern_a, 0);
    check("rst_ready_b", ready_b, 0);
    rstn = 1'b1;
    tick();

    // Basic load at 0x010, both latencies in parallel.
    start_load(10'h010);
    for (int e = 0; e < 10; e++) begin
      ea = (e < TP) ? AW'(10'h010 + e) : '0;
      check("en_a", en_a, (e < TP));
      check("addr_a", addr_a, ea);
      check("en_b", en_b, (e < TP));
      check("addr_b", addr_b, ea);
      check("busy_a", busy_a, (e < TP + 2));
      check("ready_a", ready_a, (e >= TP + 2 + SH));
      check("busy_b", busy_b, (e < TP + 4));
      check("ready_b", ready_b, (e >= TP + 4 + SH));
      tick();
    end
    check("kern_a", kern_a, bank_a0);
    check("kern_b", kern_b, bank_a0);
    check("mac2_slot0", kern_a[kernel_offset(2, 0, TP, KW) +: KW], rom_word(2, 10'h010));
    check("mac2_slot2", kern_a[kernel_offset(2, 2, TP, KW) +: KW], rom_word(2, 10'h012));
    check("err_a_basic", err_a, 0);

    // Wrapping load from DONE; old kernels visible until the first capture.
    start_load(10'h3FF);
    for (int e = 0; e < 10; e++) begin
      check("wrap_addr_a", addr_a, (e < TP) ? wrap_addr[e] : '0);
      check("wrap_addr_b", addr_b, (e < TP) ? wrap_addr[e] : '0);
      check("wrap_ready_a", ready_a, (e >= TP + 2 + SH));
`ifdef WL_SHADOW_EN
      if (e < TP + 2) check("hold_a", kern_a, bank_a0);
      else            check("switch_a", kern_a, bank_w);
      if (e < TP + 4) check("hold_b", kern_b, bank_a0);
      else            check("switch_b", kern_b, bank_w);
`else
      if (e <= 1)          check("hold_a", kern_a, bank_a0);
      else if (e >= TP + 1) check("wrap_kern_a", kern_a, bank_w);
      if (e <= 3)          check("hold_b", kern_b, bank_a0);
      else if (e >= TP + 3) check("wrap_kern_b", kern_b, bank_w);
`endif
      tick();
    end
    check("wrap_slot0", kern_a[kernel_offset(1, 0, TP, KW) +: KW], rom_word(1, 10'h3FF));
    check("wrap_slot1", kern_a[kernel_offset(1, 1, TP, KW) +: KW], rom_word(1, 10'h000));

    // Second start while busy is ignored and flags o_err.
    start_load(10'h100);
    check("coll_err0", err_a, 0);
    check("coll_addr0", addr_a, 10'h100);
    tick();
    check("coll_addr1", addr_a, 10'h101);
    start_load(10'h200);
    check("coll_err_a", err_a, 1);
    check("coll_err_b", err_b, 1);
    check("coll_addr2", addr_a, 10'h102);
    check("coll_busy", busy_a, 1);
    repeat (8) tick();
    check("coll_ready_a", ready_a, 1);
    check("coll_ready_b", ready_b, 1);
    check("coll_kern_a", kern_a, exp_bank(10'h100));
    check("coll_kern_b", kern_b, exp_bank(10'h100));
    check("coll_err_sticky", err_a, 1);

    // Reset in the middle of a load.
    start_load(10'h020);
    tick();
    tick();
    @(posedge clk);
    rstn = 1'b0;
    #1;
    check("mid_busy", busy_a, 0);
    check("mid_ready", ready_a, 0);
    check("mid_kern", kern_a, 0);
    check("mid_kern_b", kern_b, 0);
    check("mid_err", err_a, 0);
    check("mid_en", en_a, 0);
    check("mid_addr", addr_a, 0);
    tick();
    rstn = 1'b1;
    tick();
    start_load(10'h030);
    repeat (9) tick();
    check("fresh_ready_a", ready_a, 1);
    check("fresh_ready_b", ready_b, 1);
    check("fresh_kern_a", kern_a, exp_bank(10'h030));
    check("fresh_kern_b", kern_b, exp_bank(10'h030));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
